mem_fill_arbiter: RTL and testbench

- Sits directly downstream of the I-cache and D-cache fill FSMs; it is the only path to the shared pipelined main memory.
- Accepts one block-fill request at a time and issues 8 consecutive word reads for the aligned 16-byte line.
- Routes each returned word, with a valid strobe, to the requesting fill FSM.
- Also forwards single-word D-cache write-through stores to memory.

---
 rtl/mem_fill_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_fill_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter.sv
// Single-port arbiter in front of pipelined main memory: serves one 8-word line fill
// at a time (D before I) and passes D-cache write-through stores straight through.
module mem_fill_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_store_req,
    input  logic [15:0] d_store_addr,
    input  logic [15:0] d_store_data,
    output logic        d_store_ack,
    output logic [15:0] i_data,
    output logic        i_data_valid,
    output logic [15:0] d_data,
    output logic        d_data_valid,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL_I = 2'd1;
    localparam logic [1:0] S_FILL_D = 2'd2;
    localparam logic [2:0] LAST_WORD = 3'd7;

    logic [1:0]  state_q, state_d;
    logic [11:0] base_q, base_d;
    logic [2:0]  ic_q, ic_d;
    logic        iss_done_q, iss_done_d;
    logic [2:0]  rc_q, rc_d;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        ic_d         = ic_q;
        iss_done_d   = iss_done_q;
        rc_d         = rc_q;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = 16'h0;
        mem_wdata    = 16'h0;
        d_store_ack  = 1'b0;
        i_data       = 16'h0;
        i_data_valid = 1'b0;
        d_data       = 16'h0;
        d_data_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_store_req) begin
                    mem_enable  = 1'b1;
                    mem_wr      = 1'b1;
                    mem_addr    = d_store_addr;
                    mem_wdata   = d_store_data;
                    d_store_ack = 1'b1;
                end else if (d_miss) begin
                    base_d  = d_addr[15:4];
                    state_d = S_FILL_D;
                end else if (i_miss) begin
                    base_d  = i_addr[15:4];
                    state_d = S_FILL_I;
                end
            end
            S_FILL_I, S_FILL_D: begin
                // The 3-bit issue counter wraps after word 7, so a flag marks issue completion
                if (!iss_done_q) begin
                    mem_enable = 1'b1;
                    mem_addr   = {base_q, ic_q, 1'b0};
                    ic_d       = ic_q + 3'd1;
                    if (ic_q == LAST_WORD) iss_done_d = 1'b1;
                end
                if (mem_rdata_valid) begin
                    if (state_q == S_FILL_I) begin
                        i_data       = mem_rdata;
                        i_data_valid = 1'b1;
                    end else begin
                        d_data       = mem_rdata;
                        d_data_valid = 1'b1;
                    end
                    rc_d = rc_q + 3'd1;
                    if (rc_q == LAST_WORD) begin
                        state_d    = S_IDLE;
                        ic_d       = 3'd0;
                        rc_d       = 3'd0;
                        iss_done_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are forced low while reset is held, even if a store is requested in IDLE
        if (!rst_n) begin
            mem_enable   = 1'b0;
            mem_wr       = 1'b0;
            mem_addr     = 16'h0;
            mem_wdata    = 16'h0;
            d_store_ack  = 1'b0;
            i_data       = 16'h0;
            i_data_valid = 1'b0;
            d_data       = 16'h0;
            d_data_valid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            base_q     <= 12'h0;
            ic_q       <= 3'd0;
            iss_done_q <= 1'b0;
            rc_q       <= 3'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            ic_q       <= ic_d;
            iss_done_q <= iss_done_d;
            rc_q       <= rc_d;
        end
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Directed bench for mem_fill_arbiter with a 4-cycle pipelined memory model returning 0xA000+word.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_miss, d_miss, d_store_req;
    logic [15:0] i_addr, d_addr, d_store_addr, d_store_data;
    logic        d_store_ack, i_data_valid, d_data_valid;
    logic [15:0] i_data, d_data;
    logic        mem_enable, mem_wr, mem_rdata_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_miss(i_miss), .i_addr(i_addr),
        .d_miss(d_miss), .d_addr(d_addr),
        .d_store_req(d_store_req), .d_store_addr(d_store_addr), .d_store_data(d_store_data),
        .d_store_ack(d_store_ack),
        .i_data(i_data), .i_data_valid(i_data_valid),
        .d_data(d_data), .d_data_valid(d_data_valid),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
    );

    // Memory: a read issued in cycle n returns in cycle n+4; not reset, so late data still arrives
    logic [3:0]       pv = 4'h0;
    logic [3:0][15:0] pa = '0;
    always @(posedge clk) begin
        pv <= {pv[2:0], mem_enable & ~mem_wr};
        pa <= {pa[2:0], mem_addr};
    end
    assign mem_rdata_valid = pv[3];
    assign mem_rdata       = pv[3] ? (16'hA000 + {13'd0, pa[3][3:1]}) : 16'h0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_enable"}, {15'd0, mem_enable}, 16'h0);
        chk({tag, " mem_wr"}, {15'd0, mem_wr}, 16'h0);
        chk({tag, " mem_addr"}, mem_addr, 16'h0);
        chk({tag, " mem_wdata"}, mem_wdata, 16'h0);
        chk({tag, " ack"}, {15'd0, d_store_ack}, 16'h0);
        chk({tag, " i_valid"}, {15'd0, i_data_valid}, 16'h0);
        chk({tag, " d_valid"}, {15'd0, d_data_valid}, 16'h0);
        chk({tag, " i_data"}, i_data, 16'h0);
        chk({tag, " d_data"}, d_data, 16'h0);
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge
    task automatic step(input string tag, input logic en, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic ack, input logic iv, input logic dv,
                        input logic [15:0] dat);
        @(negedge clk);
        chk({tag, " mem_enable"}, {15'd0, mem_enable}, {15'd0, en});
        chk({tag, " mem_wr"}, {15'd0, mem_wr}, {15'd0, wr});
        if (en) chk({tag, " mem_addr"}, mem_addr, addr);
        if (en && wr) chk({tag, " mem_wdata"}, mem_wdata, wdata);
        chk({tag, " ack"}, {15'd0, d_store_ack}, {15'd0, ack});
        chk({tag, " i_valid"}, {15'd0, i_data_valid}, {15'd0, iv});
        chk({tag, " d_valid"}, {15'd0, d_data_valid}, {15'd0, dv});
        if (iv) chk({tag, " i_data"}, i_data, dat);
        if (dv) chk({tag, " d_data"}, d_data, dat);
        @(posedge clk);
        #1;
    endtask

    // Cycles 1..last_c of a fill granted in the previous cycle
    task automatic fill(input bit is_i, input logic [15:0] line, input int drop_c,
                        input int store_c, input int last_c);
        for (int c = 1; c <= last_c; c++) begin
            if (c == drop_c) begin
                if (is_i) i_miss = 1'b0; else d_miss = 1'b0;
            end
            if (c == store_c) begin
                d_store_req  = 1'b1;
                d_store_addr = 16'h3004;
                d_store_data = 16'h1357;
            end
            step($sformatf("%s_%h c%0d", is_i ? "ifill" : "dfill", line, c),
                 c <= 8, 1'b0, line + 16'(2 * (c - 1)), 16'h0, 1'b0,
                 is_i && c >= 5, !is_i && c >= 5, 16'hA000 + 16'(c - 5));
        end
        if (last_c == 12) begin
            if (is_i) i_miss = 1'b0; else d_miss = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_miss = 1'b0; i_addr = 16'h0;
        d_miss = 1'b0; d_addr = 16'h0;
        d_store_req = 1'b1; d_store_addr = 16'h1111; d_store_data = 16'h2222;
        #2;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset held");
        d_store_req = 1'b0;
        rst_n = 1'b1;

        // I fill alone, then store + d_miss together in the first IDLE cycle (cycle 13)
        i_miss = 1'b1; i_addr = 16'h1234;
        step("t1 c0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b1, 16'h1230, 0, 0, 12);
        d_store_req = 1'b1; d_store_addr = 16'h2002; d_store_data = 16'hBEEF;
        d_miss = 1'b1; d_addr = 16'h2010;
        step("t3 store", 1'b1, 1'b1, 16'h2002, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0);
        d_store_req = 1'b0;
        step("t3 grant", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b0, 16'h2010, 0, 0, 12);

        // Simultaneous misses: D first, I granted at cycle 13, store raised mid I-fill waits
        d_miss = 1'b1; d_addr = 16'h8006;
        i_miss = 1'b1; i_addr = 16'h0040;
        step("t2 c0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b0, 16'h8000, 0, 0, 12);
        step("t2 c13 grant I", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b1, 16'h0040, 0, 3, 12);
        step("t4 store", 1'b1, 1'b1, 16'h3004, 16'h1357, 1'b1, 1'b0, 1'b0, 16'h0);
        d_store_req = 1'b0;

        // i_miss dropped after two issues; fill completes, IDLE at 13 shown by store ack
        i_miss = 1'b1; i_addr = 16'h4446;
        step("t6 c0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b1, 16'h4440, 3, 0, 12);
        d_store_req = 1'b1; d_store_addr = 16'h3004; d_store_data = 16'h1357;
        step("t6 c13 store", 1'b1, 1'b1, 16'h3004, 16'h1357, 1'b1, 1'b0, 1'b0, 16'h0);
        d_store_req = 1'b0;

        // Reset after the 3rd returned word; late returns are dropped; fill restarts at word 0
        i_miss = 1'b1; i_addr = 16'h5678;
        step("t5 c0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b1, 16'h5670, 0, 0, 7);
        rst_n = 1'b0;
        i_miss = 1'b0;
        #1;
        chk_all_zero("t5 async");
        step("t5 rst c8", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step("t5 rst c9", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step("t5 rst c10", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
        step("t5 late c11", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        step("t5 late c12", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        i_miss = 1'b1;
        step("t5 restart c0", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        fill(1'b1, 16'h5670, 0, 0, 12);
        step("final idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
